div_share_arbiter: RTL
======================

// Module: div_share_arbiter
// PURPOSE
//  Shares one unsigned iterative divider (start/ready handshake, WIDTH-bit
//  dividend/divisor, quotient + remainder) among NREQ requesters. Round-robin
//  arbitration, one division in flight at a time. Divide-by-zero is answered
//  locally; a hung divider is caught by a watchdog. Sits between client blocks
//  and the shared divider instance.
// PARAMETERS
//  WIDTH     16   operand/result width; must match the divider's WIDTH
//  NREQ      4    number of requesters (2..8)
//  IDX_W     2    clog2(NREQ); width of requester index
//  TIMEOUT   40   WAIT cycles without div_ready before watchdog fires (>WIDTH+2)
// PORTS
//  clock         in   1           rising-edge clock
//  reset         in   1           synchronous, active-high reset
//  req_valid     in   NREQ        per-requester request
//  req_ready     out  NREQ        one-hot accept pulse; operands sampled that cycle
//  req_dividend  in   NREQ*WIDTH  packed; requester i at [i*WIDTH +: WIDTH]
//  req_divisor   in   NREQ*WIDTH  packed, same layout
//  rsp_valid     out  1           response valid; held until rsp_ready
//  rsp_ready     in   1           response consumed when rsp_valid&&rsp_ready
//  rsp_id        out  IDX_W       requester index the response belongs to
//  rsp_quotient  out  WIDTH       quotient
//  rsp_remainder out  WIDTH       remainder
//  rsp_error     out  1           divisor was zero
//  rsp_timeout   out  1           watchdog fired; quotient/remainder = 0
//  div_start     out  1           one-cycle start pulse to divider
//  div_dividend  out  WIDTH       registered; stable from ISSUE to end of WAIT
//  div_divisor   out  WIDTH       registered; stable from ISSUE to end of WAIT
//  div_quotient  in   WIDTH       divider quotient
//  div_remainder in   WIDTH       divider remainder
//  div_ready     in   1           divider done (level; cleared by divider on start)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, watchdog 0. Reset mid-op
//   aborts the job silently (no response); divider is not reset by this block.
//  States: IDLE, ISSUE, WAIT, RESP.
//  IDLE: if any req_valid: grant first requester at or after rr pointer
//   (wrapping); req_ready[g]=1 that cycle only; latch operands, rsp_id=g;
//   pointer <= g+1 mod NREQ. Divisor==0 -> RESP with rsp_error=1,
//   quotient=all-ones, remainder=dividend. Else -> ISSUE.
//  ISSUE: div_start=1 one cycle; watchdog cleared -> WAIT.
//  WAIT: first WAIT cycle ignores div_ready (stale level from previous job).
//   Afterwards div_ready=1 -> capture div_quotient/div_remainder -> RESP.
//   Watchdog increments each WAIT cycle; reaching TIMEOUT -> RESP with
//   rsp_timeout=1, results 0. Divider operands held throughout.
//  RESP: rsp_valid=1, all rsp_* stable until rsp_ready; on handshake -> IDLE.
//   No new grant in the handshake cycle (min 1 IDLE cycle between jobs).
//  Latency (nonzero divisor, rsp_ready tied 1): accept at cycle 0, start at 1,
//   rsp_valid = 1 cycle after first div_ready seen. Zero divisor: rsp_valid at 1.
//  req_ready never asserted outside IDLE; requesters hold req_valid until granted.
//  Back-pressure: rsp_ready low stalls indefinitely in RESP; watchdog idle there.
//  NREQ not power of two: pointer wraps at NREQ-1 -> 0; indices >=NREQ unused.
// STRUCTURE
//  Package div_arb_pkg: state enum (IDLE/ISSUE/WAIT/RESP), default WIDTH,
//   NREQ, TIMEOUT constants, clog2 function.
//  Sub-module rr_arbiter (NREQ req vector + pointer -> one-hot grant + index),
//   purely combinational; pointer register lives in div_share_arbiter.
// TESTING (bench instantiates the real divider behind this block)
//  Single req0 100/7 -> req_ready[0] pulse, one div_start, rsp id=0 Q=14 R=2.
//  All 4 req_valid held, rsp_ready=1 -> grant order 0,1,2,3,0; each rsp_id
//   matches grant; 65535/255 -> Q=257 R=0.
//  req2 divisor 0, dividend 1234 -> no div_start; next cycle rsp_valid,
//   rsp_error=1, Q=16'hFFFF, R=1234.
//  rsp_ready low 10 cycles after rsp_valid -> outputs stable, no new req_ready,
//   pending req granted only after handshake+1 IDLE cycle.
//  Divider model never raises div_ready -> rsp_timeout=1 after TIMEOUT WAIT
//   cycles, Q=R=0, then normal service resumes.
//  reset asserted in WAIT -> next cycle all outputs 0, IDLE, pointer 0, no rsp.

Source files
------------

// File: rtl/div_share_arbiter_pkg.sv
// Shared types and defaults for the divider-sharing arbiter.
package div_arb_pkg;

  localparam int unsigned DefWidth   = 16;
  localparam int unsigned DefNreq    = 4;
  localparam int unsigned DefTimeout = 40;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_e;

  // Ceiling log2 with a floor of 1 so single-entry indices still get a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((33'd1 << i) < {1'b0, n}) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_share_arbiter_if.sv
// Requester, response and divider-side signals of the divider-sharing arbiter.
interface div_share_arbiter_if
  import div_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned NREQ  = DefNreq,
  parameter int unsigned IDX_W = clog2(NREQ)
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_dividend;
  logic [NREQ*WIDTH-1:0] req_divisor;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDX_W-1:0]      rsp_id;
  logic [WIDTH-1:0]      rsp_quotient;
  logic [WIDTH-1:0]      rsp_remainder;
  logic                  rsp_error;
  logic                  rsp_timeout;

  logic                  div_start;
  logic [WIDTH-1:0]      div_dividend;
  logic [WIDTH-1:0]      div_divisor;
  logic [WIDTH-1:0]      div_quotient;
  logic [WIDTH-1:0]      div_remainder;
  logic                  div_ready;

  // The arbiter itself.
  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    input  div_quotient, div_remainder, div_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_error, rsp_timeout,
    output div_start, div_dividend, div_divisor
  );

  // Clients plus the shared divider.
  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    output div_quotient, div_remainder, div_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_error, rsp_timeout,
    input  div_start, div_dividend, div_divisor
  );

endinterface

// File: rtl/div_share_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after the pointer, wrapping at NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = IDX_W'((32'(ptr) + off) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one iterative divider among NREQ requesters, round-robin, one job in flight.
// Zero divisors are answered locally; a watchdog catches a divider that never finishes.
module div_share_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned NREQ    = DefNreq,
  parameter int unsigned IDX_W   = clog2(NREQ),
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input logic                clock,
  input logic                reset,
  div_share_arbiter_if.slave bus
);

  localparam int unsigned WdW = clog2(TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] id_q, id_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;

  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] sel_dvd;
  logic [WIDTH-1:0] sel_dvs;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt[i]) begin
        sel_dvd = bus.req_dividend[i*WIDTH +: WIDTH];
        sel_dvs = bus.req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    wd_d    = wd_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    err_d   = err_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_any) begin
          ptr_d = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          id_d  = gnt_idx;
          dvd_d = sel_dvd;
          dvs_d = sel_dvs;
          err_d = 1'b0;
          tmo_d = 1'b0;
          if (sel_dvs == '0) begin
            err_d   = 1'b1;
            quot_d  = '1;
            rem_d   = sel_dvd;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        wd_d = wd_q + 1'b1;
        // wd_q == 0 marks the first WAIT cycle, where div_ready may be left over.
        if (wd_q != '0 && bus.div_ready) begin
          quot_d  = bus.div_quotient;
          rem_d   = bus.div_remainder;
          state_d = StResp;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          quot_d  = '0;
          rem_d   = '0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      id_q    <= '0;
      wd_q    <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      wd_q    <= wd_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Accept pulse is gated by reset so a requester never sees a grant that is thrown away.
  assign bus.req_ready     = (state_q == StIdle && !reset) ? gnt : '0;
  assign bus.rsp_valid     = (state_q == StResp);
  assign bus.rsp_id        = id_q;
  assign bus.rsp_quotient  = quot_q;
  assign bus.rsp_remainder = rem_q;
  assign bus.rsp_error     = err_q;
  assign bus.rsp_timeout   = tmo_q;
  assign bus.div_start     = (state_q == StIssue);
  assign bus.div_dividend  = dvd_q;
  assign bus.div_divisor   = dvs_q;

  req_ready_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0(bus.req_ready));
  start_single: assert property (@(posedge clock) disable iff (reset)
    bus.div_start |=> !bus.div_start);

endmodule
